// File: rtl/mobo_bus_ctrl.sv
// CPU-to-device bus controller: decodes the top address bits to one of N_DEV
// ctrl/stat channels and runs a request/release handshake with a timeout.
module mobo_bus_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int N_DEV      = 4,
  parameter int SEL_W      = 4,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_WIDTH-1:0]       cpu_ctrl,
  output logic [WORD_WIDTH-1:0]       cpu_stat,
  input  logic [WORD_WIDTH-1:0]       cpu_addr,
  input  logic [WORD_WIDTH-1:0]       cpu_wdata,
  output logic [WORD_WIDTH-1:0]       cpu_rdata,
  output logic [N_DEV*WORD_WIDTH-1:0] dev_ctrl,
  input  logic [N_DEV*WORD_WIDTH-1:0] dev_stat,
  output logic [WORD_WIDTH-1:0]       dev_addr,
  output logic [WORD_WIDTH-1:0]       dev_wdata,
  input  logic [N_DEV*WORD_WIDTH-1:0] dev_rdata
);
  localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  localparam logic [WORD_WIDTH-1:0] SEL_MASK  = {{SEL_W{1'b1}}, {(WORD_WIDTH-SEL_W){1'b0}}};
  localparam logic [WORD_WIDTH-1:0] STAT_IDLE = '0;
  localparam logic [WORD_WIDTH-1:0] STAT_DONE = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] STAT_ERR  = WORD_WIDTH'(2);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_DONE, S_ERR} state_t;

  state_t                            state;
  logic [IDX_W-1:0]                  idx;
  logic                              is_rd;
  logic [TO_W-1:0]                   cnt;
  logic [N_DEV-1:0][WORD_WIDTH-1:0]  ctrl_q, stat_v, rdata_v;
  logic [N_DEV-1:0]                  done_v;

  assign stat_v   = dev_stat;
  assign rdata_v  = dev_rdata;
  assign dev_ctrl = ctrl_q;

  for (genvar g = 0; g < N_DEV; g++) begin : g_ch
    assign done_v[g] = stat_v[g][0];
  end

  logic [SEL_W-1:0] sel;
  logic             sel_ok, one_op, done_sel, expired;
  assign sel      = cpu_addr[WORD_WIDTH-1 -: SEL_W];
  assign sel_ok   = {1'b0, sel} < (SEL_W+1)'(N_DEV);
  assign one_op   = cpu_ctrl[0] ^ cpu_ctrl[1];
  assign done_sel = done_v[idx];
  assign expired  = (cnt == TO_LAST);

  // Only ctrl[1:0] and stat bit0 carry meaning; the rest is deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{cpu_ctrl[WORD_WIDTH-1:2], stat_v};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cpu_stat  <= STAT_IDLE;
      cpu_rdata <= '0;
      ctrl_q    <= '0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      cnt       <= '0;
      idx       <= '0;
      is_rd     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cpu_stat <= STAT_IDLE;
          cnt      <= '0;
          if (one_op && sel_ok) begin
            idx                       <= sel[IDX_W-1:0];
            is_rd                     <= cpu_ctrl[0];
            dev_addr                  <= cpu_addr & ~SEL_MASK;
            dev_wdata                 <= cpu_wdata;
            ctrl_q[sel[IDX_W-1:0]]    <= WORD_WIDTH'(cpu_ctrl[1:0]);
            state                     <= S_REQ;
          end else if (cpu_ctrl[1:0] != 2'b00) begin
            cpu_stat <= STAT_ERR;
            state    <= S_ERR;
          end
        end
        S_REQ: begin
          if (done_sel) begin
            if (is_rd) cpu_rdata <= rdata_v[idx];
            ctrl_q <= '0;
            cnt    <= '0;
            state  <= S_REL;
          end else if (expired) begin
            ctrl_q   <= '0;
            cnt      <= '0;
            cpu_stat <= STAT_ERR;
            state    <= S_ERR;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        S_REL: begin
          if (!done_sel) begin
            cnt      <= '0;
            cpu_stat <= STAT_DONE;
            state    <= S_DONE;
          end else if (expired) begin
            cnt      <= '0;
            cpu_stat <= STAT_ERR;
            state    <= S_ERR;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        S_DONE: begin
          // A held request must not re-trigger; wait for the CPU to drop it.
          if (cpu_ctrl[1:0] == 2'b00) begin
            cpu_stat <= STAT_IDLE;
            state    <= S_IDLE;
          end
        end
        S_ERR: begin
          ctrl_q <= '0;
          if (cpu_ctrl[1:0] == 2'b00) begin
            cpu_stat <= STAT_IDLE;
            state    <= S_IDLE;
          end
        end
        default: begin
          ctrl_q   <= '0;
          cpu_stat <= STAT_IDLE;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mobo_bus_ctrl.sv
// Scoreboard bench for mobo_bus_ctrl: device models with selectable ack
// behaviour, expected CPU/device transactions queued and checked on completion.
module tb_mobo_bus_ctrl;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   cpu_ctrl, cpu_stat, cpu_addr, cpu_wdata, cpu_rdata, dev_addr, dev_wdata;
  logic [N*W-1:0] dev_ctrl, dev_stat, dev_rdata;

  int total = 0;
  int bad   = 0;
  int mode  = 0;   // 0 comb ack, 1 ack 2 cycles late, 2 never ack, 3 never release
  int dly [N];
  logic stuck [N];
  logic [N*W-1:0] prev_ctrl = '0;

  typedef struct { logic [W-1:0] stat; logic [W-1:0] rdata; } exp_t;
  typedef struct { int dev; logic [W-1:0] ctrl; logic [W-1:0] addr; logic [W-1:0] wdata; } dtx_t;
  exp_t sb[$];
  dtx_t dexp[$];
  dtx_t dobs[$];

  mobo_bus_ctrl #(.WORD_WIDTH(W), .N_DEV(N), .SEL_W(4), .TIMEOUT(TO), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .cpu_ctrl(cpu_ctrl), .cpu_stat(cpu_stat), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dev_ctrl(dev_ctrl), .dev_stat(dev_stat),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    dev_stat = '0;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: dev_stat[i*W] = |dev_ctrl[i*W +: 2];
        1: dev_stat[i*W] = (|dev_ctrl[i*W +: 2]) && (dly[i] >= 2);
        3: dev_stat[i*W] = (|dev_ctrl[i*W +: 2]) || stuck[i];
        default: dev_stat[i*W] = 1'b0;
      endcase
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      dly[i]   <= (|dev_ctrl[i*W +: 2]) ? dly[i] + 1 : 0;
      stuck[i] <= (mode == 3) && (stuck[i] || (|dev_ctrl[i*W +: 2]));
    end
  end

  // Record each device request as it appears on a channel.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (dev_ctrl[i*W +: W] != '0 && prev_ctrl[i*W +: W] == '0)
        dobs.push_back('{i, dev_ctrl[i*W +: W], dev_addr, dev_wdata});
    prev_ctrl = dev_ctrl;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_dev(input string name);
    dtx_t e, o;
    total++;
    if (dobs.size() !== dexp.size()) begin
      bad++;
      $display("FAIL %s dev_tx_count: got %0d required %0d", name, dobs.size(), dexp.size());
    end
    while (dexp.size() > 0 && dobs.size() > 0) begin
      e = dexp.pop_front();
      o = dobs.pop_front();
      total++;
      if (o.dev !== e.dev || o.ctrl !== e.ctrl || o.addr !== e.addr || o.wdata !== e.wdata) begin
        bad++;
        $display("FAIL %s dev_tx: got dev=%0d ctrl=%h addr=%h wdata=%h required dev=%0d ctrl=%h addr=%h wdata=%h",
                 name, o.dev, o.ctrl, o.addr, o.wdata, e.dev, e.ctrl, e.addr, e.wdata);
      end
    end
    dexp.delete();
    dobs.delete();
  endtask

  task automatic run_txn(input logic [W-1:0] ctrl, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                         input int dev, input logic [W-1:0] exp_stat, input logic [W-1:0] exp_rdata,
                         input int exp_edges, input string name);
    exp_t e;
    int edges;
    logic [N*W-1:0] seen, allow;
    cpu_ctrl = ctrl; cpu_addr = addr; cpu_wdata = wdata;
    e.stat = exp_stat; e.rdata = exp_rdata;
    sb.push_back(e);
    allow = '0;
    if (dev >= 0) begin
      dexp.push_back('{dev, ctrl & 32'h3, addr & 32'h0FFF_FFFF, wdata});
      allow[dev*W +: W] = '1;
    end
    edges = 0; seen = '0;
    do begin
      @(negedge clk);
      edges++;
      seen |= dev_ctrl;
      // Garble the CPU side after acceptance; it must be ignored.
      cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'h0;
    end while (cpu_stat == '0 && edges < 64);
    e = sb.pop_front();
    total++;
    if (cpu_stat !== e.stat) begin bad++; $display("FAIL %s stat: got %h required %h", name, cpu_stat, e.stat); end
    total++;
    if (cpu_rdata !== e.rdata) begin bad++; $display("FAIL %s rdata: got %h required %h", name, cpu_rdata, e.rdata); end
    if (exp_edges > 0) begin
      total++;
      if (edges !== exp_edges) begin bad++; $display("FAIL %s latency: got %0d required %0d", name, edges, exp_edges); end
    end
    total++;
    if ((seen & ~allow) !== '0) begin bad++; $display("FAIL %s stray_ctrl: got %h required 0", name, seen & ~allow); end
    total++;
    if (dev_ctrl !== '0) begin bad++; $display("FAIL %s ctrl_after: got %h required 0", name, dev_ctrl); end
    cpu_ctrl = '0;
    @(negedge clk);
    total++;
    if (cpu_stat !== '0) begin bad++; $display("FAIL %s back_to_idle: got %h required 0", name, cpu_stat); end
    check_dev(name);
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_ctrl = '0; cpu_addr = '0; cpu_wdata = '0;
    dev_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    repeat (2) @(negedge clk);
    total++;
    if (cpu_stat !== '0 || cpu_rdata !== '0) begin
      bad++; $display("FAIL reset_cpu: got stat=%h rdata=%h required 0 0", cpu_stat, cpu_rdata);
    end
    total++;
    if (dev_ctrl !== '0 || dev_addr !== '0 || dev_wdata !== '0) begin
      bad++; $display("FAIL reset_dev: got ctrl=%h addr=%h wdata=%h required 0", dev_ctrl, dev_addr, dev_wdata);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    mode = 1;
    run_txn(32'h2, 32'h2000_0010, 32'hDEAD_BEEF, 2, 32'h1, 32'h0, 0, "write_dev2");
  endtask

  task automatic test_read_latency();
    mode = 0;
    dev_rdata[1*W +: W] = 32'h1234_5678;
    run_txn(32'h1, 32'h1000_0004, 32'h55, 1, 32'h1, 32'h1234_5678, 3, "read_dev1");
  endtask

  task automatic test_errors();
    run_txn(32'h1, 32'hF000_0000, 32'h0, -1, 32'h2, 32'h1234_5678, 1, "bad_select");
    run_txn(32'h3, 32'h0000_0000, 32'h0, -1, 32'h2, 32'h1234_5678, 1, "illegal_op");
  endtask

  task automatic test_timeout();
    mode = 2;
    run_txn(32'h2, 32'h3000_0008, 32'h99, 3, 32'h2, 32'h1234_5678, 1 + TO, "timeout_req");
    mode = 3;
    dev_rdata[3*W +: W] = 32'hCAFE_F00D;
    run_txn(32'h1, 32'h3000_000C, 32'h0, 3, 32'h2, 32'hCAFE_F00D, 2 + TO, "timeout_rel");
    mode = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold();
    exp_t e;
    int edges;
    mode = 0;
    dev_rdata[0*W +: W] = 32'hA5A5_5A5A;
    cpu_ctrl = 32'h1; cpu_addr = 32'h0000_0100; cpu_wdata = 32'h0;
    e.stat = 32'h1; e.rdata = 32'hA5A5_5A5A;
    sb.push_back(e);
    dexp.push_back('{0, 32'h1, 32'h0000_0100, 32'h0});
    edges = 0;
    do begin @(negedge clk); edges++; end while (cpu_stat == '0 && edges < 64);
    e = sb.pop_front();
    total++;
    if (cpu_stat !== e.stat || cpu_rdata !== e.rdata) begin
      bad++; $display("FAIL hold_first: got stat=%h rdata=%h required %h %h", cpu_stat, cpu_rdata, e.stat, e.rdata);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (cpu_stat !== 32'h1) begin bad++; $display("FAIL hold_stat cycle %0d: got %h required 1", k, cpu_stat); end
    end
    check_dev("hold");
    cpu_ctrl = '0;
    @(negedge clk);
    total++;
    if (cpu_stat !== '0) begin bad++; $display("FAIL hold_release: got %h required 0", cpu_stat); end
  endtask

  task automatic test_async_reset();
    mode = 2;
    cpu_ctrl = 32'h2; cpu_addr = 32'h1000_0020; cpu_wdata = 32'h77;
    dexp.push_back('{1, 32'h2, 32'h0000_0020, 32'h77});
    repeat (2) @(negedge clk);
    total++;
    if (dev_ctrl[1*W +: W] !== 32'h2) begin bad++; $display("FAIL areset_pre: got %h required 2", dev_ctrl[1*W +: W]); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (dev_ctrl !== '0 || cpu_stat !== '0 || cpu_rdata !== '0) begin
      bad++; $display("FAIL areset_now: got ctrl=%h stat=%h rdata=%h required 0 0 0", dev_ctrl, cpu_stat, cpu_rdata);
    end
    cpu_ctrl = '0;
    @(negedge clk);
    rst = 1'b1;
    mode = 0;
    @(negedge clk);
    check_dev("areset_abort");
    dev_rdata[2*W +: W] = 32'h0BAD_F00D;
    run_txn(32'h1, 32'h2000_0040, 32'h0, 2, 32'h1, 32'h0BAD_F00D, 3, "after_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_errors();
    test_timeout();
    test_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mobo_bus_ctrl.md
Name: mobo_bus_ctrl

Overview:
- Parametrised successor to the motherboard bus controller.
- Arbitrates single CPU ctrl/stat transactions onto N_DEV device channels, each with its own ctrl/stat pair.
- Selects the device from the top address bits and forwards the low bits as an offset.
- Adds a per-transaction timeout, error status, a full request/release handshake on the device side, and a registered read-data return.

Parameters:
- WORD_WIDTH, 32, width of ctrl, stat, address and data words.
- N_DEV, 4, number of device channels (1..2^SEL_W).
- SEL_W, 4, number of top address bits used as device select.
- TIMEOUT, 255, maximum cycles spent in any wait state before error (>=1).
- TO_W, 16, timeout counter width; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- cpu_ctrl  in  WORD_WIDTH  CPU request: bit0 CTRL_READ, bit1 CTRL_WRITE; other bits ignored.
- cpu_stat  out  WORD_WIDTH  status to CPU: 0 STAT_IDLE, 1 STAT_DONE, 2 STAT_ERR.
- cpu_addr  in  WORD_WIDTH  CPU address; [WORD_WIDTH-1 -: SEL_W] is the device select.
- cpu_wdata  in  WORD_WIDTH  CPU write data.
- cpu_rdata  out  WORD_WIDTH  read data returned to CPU.
- dev_ctrl  out  N_DEV*WORD_WIDTH  per-device ctrl; device i occupies slice [i*WORD_WIDTH +: WORD_WIDTH]; same READ/WRITE encoding as cpu_ctrl.
- dev_stat  in  N_DEV*WORD_WIDTH  per-device status; bit0 = done.
- dev_addr  out  WORD_WIDTH  offset = cpu_addr with select bits zeroed, shared by all devices.
- dev_wdata  out  WORD_WIDTH  latched write data, shared by all devices.
- dev_rdata  in  N_DEV*WORD_WIDTH  per-device read data, same slicing as dev_ctrl.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) forces: state IDLE; cpu_stat=0; cpu_rdata=0; dev_ctrl=0; dev_addr=0; dev_wdata=0; counter=0; idx=0.
- Reset asserted mid-transaction aborts the transaction immediately, with no completion reported.
- States: IDLE, REQ, REL, DONE, ERR.

IDLE:
- cpu_stat=IDLE.
- If exactly one of cpu_ctrl[1:0] is set:
  - sel = select bits.
  - If sel < N_DEV: latch idx=sel, dev_addr=offset, dev_wdata=cpu_wdata, op; go to REQ.
  - Otherwise go to ERR.
- cpu_ctrl[1:0]==2'b11: go to ERR (illegal operation).
- cpu_ctrl[1:0]==0: stay in IDLE.

REQ:
- dev_ctrl[idx]=op; all other dev_ctrl slices are 0.
- On the first edge where dev_stat[idx][0]==1:
  - For a read, latch cpu_rdata = dev_rdata[idx].
  - Clear dev_ctrl[idx]; go to REL.

REL:
- dev_ctrl all 0.
- Wait for dev_stat[idx][0]==0, then go to DONE with cpu_stat=DONE.

Timeout:
- The counter clears on every state entry and increments each cycle in REQ and REL.
- When counter == TIMEOUT-1 and the awaited condition is still false, go to ERR.

DONE:
- cpu_stat=DONE until cpu_ctrl==0, then go to IDLE; cpu_stat=IDLE on the same edge.
- cpu_rdata holds its value until the next read.
- Writes leave cpu_rdata unchanged.

ERR:
- cpu_stat=ERR; dev_ctrl all 0.
- When cpu_ctrl==0, go to IDLE.

Other rules:
- No new transaction is accepted until the CPU has dropped cpu_ctrl; a held request never re-triggers.
- Changes to cpu_ctrl, cpu_addr or cpu_wdata after IDLE are ignored until return to IDLE.
- Latency: with a device whose stat follows its ctrl combinationally, cpu_stat=DONE is visible 3 edges after cpu_ctrl is sampled in IDLE.
- A device that never releases done in REL also times out to ERR.
- dev_stat of non-selected devices is ignored.

Test Plan:
- Write, N_DEV=4: cpu_addr=0x2000_0010, cpu_wdata=0xDEADBEEF, ctrl=2, with a device model acking 2 cycles after ctrl -> dev_ctrl slice2=2, dev_addr=0x0000_0010, dev_wdata=0xDEADBEEF, cpu_stat=1; cpu_stat returns to 0 one edge after ctrl=0.
- Read from device 1 with combinational ack and dev_rdata=0x12345678 -> cpu_rdata=0x12345678 and cpu_stat=1 exactly 3 edges after request; other dev_ctrl slices stay 0 throughout.
- Bad select 0xF000_0000, and ctrl=3 at a valid address -> each gives cpu_stat=2 after 1 edge, dev_ctrl never nonzero, return to IDLE after ctrl=0.
- TIMEOUT=8, device never acks -> ERR after exactly 8 cycles in REQ, dev_ctrl cleared; device acks but never releases -> ERR after 8 cycles in REL.
- CPU holds ctrl=1 for 20 cycles after DONE -> exactly one device transaction, cpu_stat stays 1.
- rst=0 asserted in REQ -> dev_ctrl, cpu_stat and cpu_rdata are 0 immediately (asynchronous); a new request after release completes normally.
